// File: rtl/vdp_super_res_writer.sv
// Super-res framebuffer write path: CPU byte writes with auto-increment address,
// buffered in a FIFO and drained to VRAM as byte-masked 32-bit word writes.
// Define VDP_SUPER_RES_WRITE_COMBINE_EN to merge same-word bytes into one write.
module vdp_super_res_writer #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vdp_super,
  input  logic        addr_load,
  input  logic [18:0] addr_in,
  input  logic        wr_strobe,
  input  logic [7:0]  wr_data,
  input  logic        super_res_drawing,
  output logic        vram_wr_req,
  output logic [16:0] vram_wr_addr,
  output logic [31:0] vram_wr_data,
  output logic [3:0]  vram_wr_mask,
  input  logic        vram_wr_ack,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

`ifdef VDP_SUPER_RES_WRITE_COMBINE_EN
  typedef enum logic [1:0] {IDLE, GATHER, REQ} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ} state_t;
`endif

  state_t        state, state_n;
  logic [18:0]   byte_addr, eff_addr;
  logic [26:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic [26:0]   head;
  logic [18:0]   head_addr;
  logic [7:0]    head_byte;
  logic [1:0]    head_lane;
  logic          not_empty, full_now, push, pop, drop, req_n;
  logic [16:0]   addr_n;
  logic [31:0]   data_n;
  logic [3:0]    mask_n;

  assign head      = mem[rd_ptr];
  assign head_addr = head[26:8];
  assign head_byte = head[7:0];
  assign head_lane = head_addr[1:0];
  assign not_empty = (count != '0);
  assign full_now  = (count == DEPTH_C);
  assign eff_addr  = addr_load ? addr_in : byte_addr;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    addr_n  = vram_wr_addr;
    data_n  = vram_wr_data;
    mask_n  = vram_wr_mask;
    unique case (state)
      IDLE: begin
        if (not_empty && !super_res_drawing) begin
          pop     = 1'b1;
          addr_n  = head_addr[18:2];
          mask_n  = 4'b0001 << head_lane;
          data_n  = 32'(head_byte) << {head_lane, 3'b000};
`ifdef VDP_SUPER_RES_WRITE_COMBINE_EN
          state_n = GATHER;
`else
          state_n = REQ;
`endif
        end
      end
`ifdef VDP_SUPER_RES_WRITE_COMBINE_EN
      GATHER: begin
        // Merge only while the head belongs to this word; never skip past an entry.
        if (not_empty && head_addr[18:2] == vram_wr_addr &&
            !vram_wr_mask[head_lane] && vram_wr_mask != 4'hF) begin
          pop    = 1'b1;
          mask_n = vram_wr_mask | (4'b0001 << head_lane);
          data_n = vram_wr_data | (32'(head_byte) << {head_lane, 3'b000});
        end else begin
          state_n = REQ;
        end
      end
`endif
      REQ: begin
        if (vram_wr_req && vram_wr_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push is accepted even when full.
  assign push  = wr_strobe && (!full_now || pop);
  assign drop  = wr_strobe && full_now && !pop;
  assign req_n = (state == REQ) && !(vram_wr_req && vram_wr_ack);

  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           state <= IDLE;
    else if (!vdp_super) state <= IDLE;
    else                 state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (push && vdp_super) mem[wr_ptr] <= {eff_addr, wr_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_addr    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      vram_wr_req  <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
      vram_wr_mask <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      overflow     <= 1'b0;
    end else if (!vdp_super) begin
      // Synchronous clear; byte_addr is deliberately retained.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      vram_wr_req  <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
      vram_wr_mask <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      overflow     <= 1'b0;
    end else begin
      if (wr_strobe)      byte_addr <= eff_addr + 19'd1;
      else if (addr_load) byte_addr <= addr_in;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count        <= count_n;
      vram_wr_req  <= req_n;
      vram_wr_addr <= addr_n;
      vram_wr_data <= data_n;
      vram_wr_mask <= mask_n;
      fifo_full    <= (count_n == DEPTH_C);
      fifo_empty   <= (count_n == '0) && (state_n == IDLE);
      if (drop)           overflow <= 1'b1;
      else if (addr_load) overflow <= 1'b0;
    end
  end

endmodule
